dm_store_buffer: RTL and testbench
==================================

# dm_store_buffer

Posted-store buffer between the MEM-stage store path and the data memory (DM). It accepts store requests (SW/SH/SB/SWL/SWR), encodes each into the DM's write form (word address, `DM_data_in`, `BYTE_WE`, `LR`), queues them in a small FIFO, and drains one entry per cycle into DM. The buffer yields the shared DM address to loads, and stalls any load whose word aliases a pending store.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `AW`, 11: stored word-address width, matching DM word index bits [12:2].
- `clk  in  1`: clock; all state updates on the rising edge.
- `reset  in  1`: asynchronous, active-low; 0 clears all state immediately.
- `st_valid  in  1`: store request this cycle.
- `st_ready  out  1`: buffer can accept; equals !full.
- `st_type  in  3`: store type (package encoding).
- `st_addr  in  32`: byte address.
- `st_data  in  32`: rt value, unshifted.
- `st_err  out  1`: misaligned store dropped; only when `DM_SB_ALIGN_CHK_EN` is defined.
- `ld_valid  in  1`: MEM-stage load needs the DM port this cycle.
- `ld_addr  in  32`: load byte address.
- `ld_stall  out  1`: load aliases a pending store and must be held.
- `DM_addr  out  32`: DM address when `dm_sel`=1; {19'b0, word, 2'b00}.
- `DM_data_in  out  32`: encoded write data.
- `DM_WE  out  1`: DM write enable.
- `LR  out  1`: SWL/SWR write form.
- `BYTE_WE  out  4`: DM byte enables.
- `dm_sel  out  1`: 1 = buffer drives the DM address mux; 0 = load path drives it.
- `empty  out  1`: no pending stores. Used for sync/halt.

## Operation
- Push: on an edge with `st_valid && st_ready`, encode the request and write it at the tail.
- Encoding, with a = addr[1:0]:
  - SW: `BYTE_WE`=1111, LR=0, data as-is.
  - SH: `BYTE_WE`=0011 if a[1]=0, else 1100. LR=0. data={2{rt[15:0]}}.
  - SB: `BYTE_WE`=1<<a, LR=0, data={4{rt[7:0]}}.
  - SWL: LR=1, data=rt. `BYTE_WE` by a=0/1/2/3 is 0001/0011/0111/1111.
  - SWR: LR=1, data=rt. `BYTE_WE` by a=0/1/2/3 is 1111/1110/1100/1000.
  - Undefined `st_type` is treated as SW.
- Drain: head is valid and `ld_valid`=0, or head is valid and `ld_stall`=1:
  - drive head fields, `DM_WE`=1, `dm_sel`=1;
  - pop on that edge.
- Otherwise `DM_WE`=0, `dm_sel`=0, and `BYTE_WE`/`LR`/`DM_data_in`/`DM_addr` = 0.
- Loads have priority for the DM port, except when stalled. Forcing the drain while stalled guarantees forward progress.
- Alias check: `ld_stall` = `ld_valid` && some valid entry with word == `ld_addr[12:2]`. Combinational; entry contents are not forwarded.
- Push and pop on the same edge: both happen and the count is unchanged. When full, a push is not accepted even if a pop occurs that edge.
- Pointers wrap modulo `DEPTH`. Full/empty come from a count of width clog2(DEPTH)+1.

## Timing
- Reset (async): pointers and count = 0; all entry valid bits = 0; pending stores discarded.
- Outputs during and after reset: `st_ready`=1, `empty`=1, `DM_WE`=0, `dm_sel`=0, `st_err`=0, `ld_stall`=0, all DM buses 0.
- Latency: a store pushed at edge N drives `DM_WE` during cycle N+1. DM commits it at edge N+1 if no load intervenes.
- Throughput: one push and one drain per cycle.
- `st_err` is registered: a one-cycle pulse after the offending push edge.
- Reset deasserting mid-cycle: the first push is taken on the next rising edge.

## Configuration
- `DM_SB_ALIGN_CHK_EN` defined:
  - SH with a[0]=1, or SW with a≠0, is not enqueued;
  - `st_err` pulses;
  - `st_ready` is unaffected.
- `DM_SB_ALIGN_CHK_EN` undefined:
  - the `st_err` port is tied 0;
  - offending low address bits are forced to 0 (SH clears a[0], SW clears a[1:0]) and the store is enqueued.

## Structure
- Shared package/header `dm_defs`:
  - store-type encodings ST_SW=0, ST_SH=1, ST_SB=2, ST_SWL=3, ST_SWR=4;
  - the entry layout {word[AW-1:0], data[31:0], be[3:0], lr};
  - the word-index field [12:2].
- Sub-module `dm_store_align`: purely combinational encoder (type, a, rt → be, data, lr, misalign). Reused by the load-side extender tests.
- FIFO storage, pointers, alias compare and output mux live in the top.

## Test plan
- After reset: SB addr 0x0000_0005, rt=0x0000_00AB → next cycle `DM_WE`=1, `BYTE_WE`=0010, `DM_data_in`=0xABABABAB, `DM_addr`=0x4, LR=0.
- SWR addr 0x11, rt=0x11223344 → `BYTE_WE`=1110, LR=1, data 0x11223344. DM word 4 bytes [31:8] become 0x223344.
- Push 4 stores back-to-back with `ld_valid` held 1 (non-aliasing) → `st_ready`=0 after the 4th, no `DM_WE`. Release `ld_valid` → four consecutive drains in FIFO order.
- SW pending to word 0x20, load of 0x22 → `ld_stall`=1 and drain forced that cycle. `ld_stall`=0 the next cycle.
- Push while full and popping the same edge → push rejected; count steps 4→3.
- Misaligned SW addr 0x3:
  - with the macro → `st_err` pulse, `empty` stays 1;
  - without it → drains to address 0x0 with `BYTE_WE`=1111.
- Assert `reset`=0 mid-queue with 3 entries → `DM_WE` drops immediately; `empty`=1 after release.

Source files
------------

// File: rtl/dm_defs.sv
// dm_defs: shared store-type encodings, buffer entry layout and DM word-index helper.
package dm_defs;
  typedef enum logic [2:0] {
    ST_SW  = 3'd0,
    ST_SH  = 3'd1,
    ST_SB  = 3'd2,
    ST_SWL = 3'd3,
    ST_SWR = 3'd4
  } st_type_e;
  localparam int DM_AW   = 11;
  localparam int WORD_HI = 12;
  localparam int WORD_LO = 2;
  typedef struct packed {
    logic [DM_AW-1:0] word;
    logic [31:0]      data;
    logic [3:0]       be;
    logic             lr;
  } sb_entry_t;
  function automatic logic [DM_AW-1:0] word_of(input logic [31:0] addr);
    return addr[WORD_HI:WORD_LO];
  endfunction
endpackage

// File: rtl/dm_store_align.sv
// dm_store_align: combinational store encoder (type, byte offset, rt -> byte enables, lane data, LR, misalign).
module dm_store_align
  import dm_defs::*;
(
  input  logic [2:0]  st_type,
  input  logic [1:0]  a,
  input  logic [31:0] rt,
  output logic [3:0]  be,
  output logic [31:0] data,
  output logic        lr,
  output logic        misalign
);
  logic is_sh, is_sb, is_swl, is_swr, is_sw;
  assign is_sh  = st_type == ST_SH;
  assign is_sb  = st_type == ST_SB;
  assign is_swl = st_type == ST_SWL;
  assign is_swr = st_type == ST_SWR;
  // undefined encodings fall through to SW behaviour
  assign is_sw  = !(is_sh || is_sb || is_swl || is_swr);
  always_comb begin
    lr       = is_swl || is_swr;
    data     = is_sh ? {2{rt[15:0]}} : is_sb ? {4{rt[7:0]}} : rt;
    be       = is_sh  ? (a[1] ? 4'b1100 : 4'b0011) :
               is_sb  ? 4'b0001 << a :
               is_swl ? 4'b1111 >> (2'd3 - a) :
               is_swr ? 4'b1111 << a : 4'b1111;
    misalign = is_sh ? a[0] : is_sw ? |a : 1'b0;
  end
endmodule

// File: rtl/dm_store_buffer.sv
// dm_store_buffer: posted-store FIFO in front of DM; loads own the port unless they alias a pending store.
// Optional DM_SB_ALIGN_CHK_EN drops misaligned SW/SH and pulses st_err instead of silently aligning them.
module dm_store_buffer
  import dm_defs::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [2:0]  st_type,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_err,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  output logic        ld_stall,
  output logic [31:0] DM_addr,
  output logic [31:0] DM_data_in,
  output logic        DM_WE,
  output logic        LR,
  output logic [3:0]  BYTE_WE,
  output logic        dm_sel,
  output logic        empty
);
  localparam int PW = $clog2(DEPTH);
  sb_entry_t        mem [DEPTH];
  sb_entry_t        head;
  logic [DEPTH-1:0] valid;
  logic [PW-1:0]    wp, rp;
  logic [PW:0]      count;
  logic [3:0]       enc_be;
  logic [31:0]      enc_data;
  logic             enc_lr, mis, push, pop, hit;

  dm_store_align u_align (
    .st_type (st_type),
    .a       (st_addr[1:0]),
    .rt      (st_data),
    .be      (enc_be),
    .data    (enc_data),
    .lr      (enc_lr),
    .misalign(mis)
  );

  assign st_ready = count != (PW+1)'(DEPTH);
  assign empty    = count == '0;

`ifdef DM_SB_ALIGN_CHK_EN
  assign push = st_valid && st_ready && !mis;
  always_ff @(posedge clk or negedge reset)
    if (!reset) st_err <= 1'b0;
    else        st_err <= st_valid && st_ready && mis;
  logic unused_addr;
  assign unused_addr = ^{st_addr[31:13], ld_addr[31:13], ld_addr[1:0]};
`else
  // low offset bits never reach the entry and the encoder ignores them for SW/SH lanes
  assign push   = st_valid && st_ready;
  assign st_err = 1'b0;
  logic unused_addr;
  assign unused_addr = ^{st_addr[31:13], ld_addr[31:13], ld_addr[1:0], mis};
`endif

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      hit = hit | (valid[i] && mem[i].word == word_of(ld_addr));
  end

  assign ld_stall   = ld_valid && hit;
  assign head       = mem[rp];
  assign pop        = valid[rp] && (!ld_valid || ld_stall);
  assign DM_WE      = pop;
  assign dm_sel     = pop;
  assign DM_addr    = pop ? {{(30-AW){1'b0}}, AW'(head.word), 2'b00} : '0;
  assign DM_data_in = pop ? head.data : '0;
  assign BYTE_WE    = pop ? head.be : '0;
  assign LR         = pop ? head.lr : 1'b0;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (push) begin
        valid[wp] <= 1'b1;
        wp        <= wp + 1'b1;
      end
      if (pop) begin
        valid[rp] <= 1'b0;
        rp        <= rp + 1'b1;
      end
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end

  always_ff @(posedge clk)
    if (push) mem[wp] <= '{word: word_of(st_addr), data: enc_data, be: enc_be, lr: enc_lr};
endmodule

// File: tb/tb_dm_store_buffer.sv
// tb_dm_store_buffer: directed self-checking bench for dm_store_buffer (default and DM_SB_ALIGN_CHK_EN builds).
module tb_dm_store_buffer;
  logic        clk = 1'b0, reset;
  logic        st_valid, st_ready, st_err, ld_valid, ld_stall;
  logic        DM_WE, LR, dm_sel, empty;
  logic [2:0]  st_type;
  logic [31:0] st_addr, st_data, ld_addr, DM_addr, DM_data_in;
  logic [3:0]  BYTE_WE;
  int          n_chk = 0, n_fail = 0;

  dm_store_buffer dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_ready(st_ready),
    .st_type(st_type), .st_addr(st_addr), .st_data(st_data), .st_err(st_err),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_stall(ld_stall),
    .DM_addr(DM_addr), .DM_data_in(DM_data_in), .DM_WE(DM_WE), .LR(LR),
    .BYTE_WE(BYTE_WE), .dm_sel(dm_sel), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1;
    st_type  = t;
    st_addr  = a;
    st_data  = d;
  endtask

  task automatic drain_chk(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be, input logic lr);
    chk({tag, "_we"}, {31'b0, DM_WE}, 1);
    chk({tag, "_sel"}, {31'b0, dm_sel}, 1);
    chk({tag, "_addr"}, DM_addr, a);
    chk({tag, "_data"}, DM_data_in, d);
    chk({tag, "_be"}, {28'b0, BYTE_WE}, {28'b0, be});
    chk({tag, "_lr"}, {31'b0, LR}, {31'b0, lr});
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_we"}, {31'b0, DM_WE}, 0);
    chk({tag, "_sel"}, {31'b0, dm_sel}, 0);
    chk({tag, "_addr"}, DM_addr, 0);
    chk({tag, "_data"}, DM_data_in, 0);
    chk({tag, "_be"}, {28'b0, BYTE_WE}, 0);
    chk({tag, "_lr"}, {31'b0, LR}, 0);
  endtask

  initial begin
    reset = 1'b0; st_valid = 1'b0; st_type = 3'd0; st_addr = '0; st_data = '0;
    ld_valid = 1'b0; ld_addr = '0;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_ready", {31'b0, st_ready}, 1);
    chk("rst_empty", {31'b0, empty}, 1);
    chk("rst_err", {31'b0, st_err}, 0);
    chk("rst_stall", {31'b0, ld_stall}, 0);
    idle_chk("rst");
    reset = 1'b1;
    step();

    put(3'd2, 32'h0000_0005, 32'h0000_00AB);
    step();
    st_valid = 1'b0;
    #1;
    drain_chk("sb", 32'h4, 32'hABAB_ABAB, 4'b0010, 1'b0);
    chk("sb_empty", {31'b0, empty}, 0);
    step();
    chk("sb_done", {31'b0, empty}, 1);
    idle_chk("sb_idle");

    put(3'd4, 32'h0000_0011, 32'h1122_3344);
    step();
    st_valid = 1'b0;
    #1;
    drain_chk("swr", 32'h10, 32'h1122_3344, 4'b1110, 1'b1);
    put(3'd3, 32'h0000_0022, 32'hA1B2_C3D4);
    step();
    #1;
    drain_chk("swl", 32'h20, 32'hA1B2_C3D4, 4'b0111, 1'b1);
    put(3'd1, 32'h0000_0006, 32'h0000_BEEF);
    step();
    #1;
    drain_chk("sh_hi", 32'h4, 32'hBEEF_BEEF, 4'b1100, 1'b0);
    put(3'd7, 32'h0000_0040, 32'h5555_AAAA);
    step();
    st_valid = 1'b0;
    #1;
    drain_chk("undef", 32'h40, 32'h5555_AAAA, 4'b1111, 1'b0);
    step();

    ld_valid = 1'b1;
    ld_addr  = 32'h0000_1000;
    for (int i = 0; i < 4; i++) begin
      put(3'd0, 32'h100 + 32'(4 * i), 32'(i + 1));
      step();
    end
    st_valid = 1'b0;
    #1;
    chk("full_ready", {31'b0, st_ready}, 0);
    chk("full_stall", {31'b0, ld_stall}, 0);
    idle_chk("full_ldprio");
    ld_valid = 1'b0;
    put(3'd0, 32'h0000_0200, 32'h0000_0005);
    #1;
    drain_chk("fifo0", 32'h100, 32'h1, 4'b1111, 1'b0);
    step();
    st_valid = 1'b0;
    #1;
    chk("pushpop_ready", {31'b0, st_ready}, 1);
    for (int i = 1; i < 4; i++) begin
      drain_chk($sformatf("fifo%0d", i), 32'h100 + 32'(4 * i), 32'(i + 1), 4'b1111, 1'b0);
      step();
    end
    chk("fifo_empty", {31'b0, empty}, 1);
    idle_chk("fifo_end");

    ld_valid = 1'b1;
    ld_addr  = 32'h0000_1000;
    put(3'd0, 32'h0000_0080, 32'h0000_CAFE);
    step();
    st_valid = 1'b0;
    ld_addr  = 32'h0000_0082;
    #1;
    chk("alias_stall", {31'b0, ld_stall}, 1);
    drain_chk("alias", 32'h80, 32'h0000_CAFE, 4'b1111, 1'b0);
    step();
    chk("alias_clear", {31'b0, ld_stall}, 0);
    chk("alias_empty", {31'b0, empty}, 1);
    put(3'd0, 32'h0000_0084, 32'h0000_0077);
    ld_addr = 32'h0000_0090;
    step();
    st_valid = 1'b0;
    #1;
    chk("noalias_stall", {31'b0, ld_stall}, 0);
    idle_chk("noalias");
    ld_valid = 1'b0;
    #1;
    drain_chk("noalias_rel", 32'h84, 32'h77, 4'b1111, 1'b0);
    step();

    put(3'd0, 32'h0000_0003, 32'h1234_5678);
    step();
    st_valid = 1'b0;
    #1;
`ifdef DM_SB_ALIGN_CHK_EN
    chk("mis_err", {31'b0, st_err}, 1);
    chk("mis_empty", {31'b0, empty}, 1);
    idle_chk("mis_drop");
    step();
    chk("mis_err_pulse", {31'b0, st_err}, 0);
`else
    chk("mis_err", {31'b0, st_err}, 0);
    drain_chk("mis", 32'h0, 32'h1234_5678, 4'b1111, 1'b0);
    step();
`endif

    ld_valid = 1'b1;
    ld_addr  = 32'h0000_1000;
    for (int i = 0; i < 3; i++) begin
      put(3'd0, 32'h300 + 32'(4 * i), 32'(i));
      step();
    end
    st_valid = 1'b0;
    ld_valid = 1'b0;
    #1;
    chk("preq_we", {31'b0, DM_WE}, 1);
    reset = 1'b0;
    #1;
    chk("arst_empty", {31'b0, empty}, 1);
    chk("arst_ready", {31'b0, st_ready}, 1);
    idle_chk("arst");
    step();
    #2;
    reset = 1'b1;
    step();
    chk("post_empty", {31'b0, empty}, 1);
    idle_chk("post");
    put(3'd0, 32'h0000_0400, 32'hDEAD_BEEF);
    step();
    st_valid = 1'b0;
    #1;
    drain_chk("post_push", 32'h400, 32'hDEAD_BEEF, 4'b1111, 1'b0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
